// File: rtl/spi_cmd_seq_if.sv
// Request and generator-facing signals of the SPI command sequencer.
// slave: the sequencer itself; master: request source plus frame generator.
interface spi_cmd_seq_if;
    logic       req_vld;
    logic [7:0] req_cmd;
    logic [7:0] req_data;
    logic       req_rdy;
    logic       start;
    logic [7:0] cmd;
    logic [7:0] data;
    logic       csb;

    modport slave (
        input  req_vld, req_cmd, req_data, csb,
        output req_rdy, start, cmd, data
    );

    modport master (
        output req_vld, req_cmd, req_data, csb,
        input  req_rdy, start, cmd, data
    );
endinterface

// File: rtl/spi_cmd_seq.sv
// Queues {cmd, data} requests and launches them one at a time into the SPI frame
// generator, tracking each frame through chip-select with timeout and inter-frame gap.
module spi_cmd_seq #(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYC     = 512,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    spi_cmd_seq_if.slave                    bus,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_timeout,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_cnt,
    output logic [CNT_W-1:0]                o_frm_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);

    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        data_q, data_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  frm_cnt_q, frm_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              csb_prev_q, csb_prev_d;

    logic req_rdy;
    logic push;
    logic pop;
    logic csb_rise;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign req_rdy  = (cnt_q != FIFO_FULL);
    assign push     = bus.req_vld & req_rdy;
    assign pop      = (state_q == S_IDLE) & i_en & (cnt_q != '0);
    assign csb_rise = bus.csb & ~csb_prev_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        csb_prev_d = bus.csb;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + FCNT_W'(1);
            2'b01:   cnt_d = cnt_q - FCNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
        state_d   = state_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        frm_cnt_d = frm_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    cmd_d   = fifo_mem[rd_ptr_q][15:8];
                    data_d  = fifo_mem[rd_ptr_q][7:0];
                    start_d = 1'b1;
                end
            end
            S_START: begin
                state_d   = S_WAIT_LOW;
                tmo_cnt_d = '0;
            end
            S_WAIT_LOW: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (!bus.csb) begin
                    state_d = S_WAIT_HIGH;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = S_GAP;
                    timeout_d = 1'b1;
                    gap_cnt_d = '0;
                end
            end
            S_WAIT_HIGH: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // Completion is checked first so a rise on the expiry cycle still counts as done.
                if (csb_rise) begin
                    state_d   = S_GAP;
                    done_d    = 1'b1;
                    frm_cnt_d = frm_cnt_q + CNT_W'(1);
                    gap_cnt_d = '0;
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    state_d   = S_GAP;
                    timeout_d = 1'b1;
                    gap_cnt_d = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses <= so every flop updates together from the pre-edge _d values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            frm_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            csb_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            start_q    <= start_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            frm_cnt_q  <= frm_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            csb_prev_q <= csb_prev_d;
        end
    end

    // NOTE: storage is not reset; pointers and occupancy alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.req_cmd, bus.req_data};
        end
    end

    assign bus.req_rdy = req_rdy;
    assign bus.start   = start_q;
    assign bus.cmd     = cmd_q;
    assign bus.data    = data_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;
    assign o_fifo_cnt  = cnt_q;
    assign o_frm_cnt   = frm_cnt_q;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed bench for spi_cmd_seq: a small frame-generator model drives csb, a negedge
// monitor logs start/done/timeout cycles, and one task per scenario checks the results.
module tb_spi_cmd_seq;

    localparam int GAP_CYC     = 512;
    localparam int TIMEOUT_CYC = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [2:0]  fifo_cnt;
    logic [15:0] frm_cnt;

    spi_cmd_seq_if bus();

    logic gen_auto = 1'b0;
    logic gen_csb  = 1'b1;
    logic man_csb  = 1'b1;
    int   gen_cnt  = 0;

    assign bus.csb = gen_auto ? gen_csb : man_csb;

    spi_cmd_seq #(
        .FIFO_DEPTH (4),
        .GAP_CYC    (GAP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (16)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .bus       (bus),
        .o_busy    (busy),
        .o_done    (done),
        .o_timeout (timeout),
        .o_fifo_cnt(fifo_cnt),
        .o_frm_cnt (frm_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: csb low from 4 to 20 cycles after the start pulse.
    always @(posedge clk) begin
        if (bus.start) gen_cnt <= 1;
        else if (gen_cnt != 0 && gen_cnt < 30) gen_cnt <= gen_cnt + 1;
        else gen_cnt <= 0;
        gen_csb <= !(gen_cnt >= 3 && gen_cnt < 20);
    end

    int          start_cyc[$];
    logic [15:0] start_word[$];
    int          done_cyc[$];
    int          tmo_cyc[$];
    int          hold_viol = 0;
    logic [15:0] prev_word = 16'h0000;

    always @(negedge clk) begin
        if (bus.start) begin
            start_cyc.push_back(cyc);
            start_word.push_back({bus.cmd, bus.data});
        end else if (rst_n && ({bus.cmd, bus.data} !== prev_word)) begin
            hold_viol++;
        end
        prev_word = {bus.cmd, bus.data};
        if (done) done_cyc.push_back(cyc);
        if (timeout) tmo_cyc.push_back(cyc);
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int get_i(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [15:0] get_w(input logic [15:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 16'hxxxx;
    endfunction

    task automatic clear_logs();
        start_cyc.delete();
        start_word.delete();
        done_cyc.delete();
        tmo_cyc.delete();
        hold_viol = 0;
    endtask

    // Advance to 1ns after the posedge that begins cycle c.
    task automatic at_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance to the negedge inside cycle c.
    task automatic at_neg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        en           = 1'b0;
        bus.req_vld  = 1'b0;
        bus.req_cmd  = 8'h00;
        bus.req_data = 8'h00;
        gen_auto     = 1'b0;
        man_csb      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    // Called at posedge+1; returns the cycle in which the request was accepted.
    task automatic push(input logic [7:0] c, input logic [7:0] d, output int acc);
        int t = 0;
        bus.req_vld  = 1'b1;
        bus.req_cmd  = c;
        bus.req_data = d;
        @(negedge clk);
        while (!bus.req_rdy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL push_accept: req_rdy=%b required 1", bus.req_rdy);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        bus.req_vld = 1'b0;
    endtask

    // sel 0 waits on done pulses, sel 1 on timeout pulses.
    task automatic wait_count(input int sel, input int n, input int bound, input string name);
        int t = 0;
        while (((sel == 0) ? done_cyc.size() : tmo_cyc.size()) < n && t < bound) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (((sel == 0) ? done_cyc.size() : tmo_cyc.size()) < n) begin
            n_fail++;
            $display("FAIL %s: %0d events seen, required %0d",
                     name, (sel == 0) ? done_cyc.size() : tmo_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        bus.req_vld  = 1'b0;
        bus.req_cmd  = 8'h00;
        bus.req_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks += 9;
        if (bus.start !== 1'b0)     begin n_fail++; $display("FAIL rst_start: got %b required 0", bus.start); end
        if (bus.cmd !== 8'h00)      begin n_fail++; $display("FAIL rst_cmd: got %h required 00", bus.cmd); end
        if (bus.data !== 8'h00)     begin n_fail++; $display("FAIL rst_data: got %h required 00", bus.data); end
        if (done !== 1'b0)          begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
        if (timeout !== 1'b0)       begin n_fail++; $display("FAIL rst_timeout: got %b required 0", timeout); end
        if (frm_cnt !== 16'd0)      begin n_fail++; $display("FAIL rst_frm_cnt: got %0d required 0", frm_cnt); end
        if (fifo_cnt !== 3'd0)      begin n_fail++; $display("FAIL rst_fifo_cnt: got %0d required 0", fifo_cnt); end
        if (bus.req_rdy !== 1'b1)   begin n_fail++; $display("FAIL rst_req_rdy: got %b required 1", bus.req_rdy); end
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int n;
        int d;
        do_reset();
        gen_auto = 1'b1;
        en       = 1'b1;
        push(8'hA5, 8'h3C, n);
        wait_count(0, 1, 200, "single_done");
        d = get_i(done_cyc, 0);
        n_checks += 5;
        if (get_i(start_cyc, 0) !== n + 2)      begin n_fail++; $display("FAIL single_latency: start at %0d required %0d", get_i(start_cyc, 0), n + 2); end
        if (get_w(start_word, 0) !== 16'hA53C)  begin n_fail++; $display("FAIL single_word: got %h required a53c", get_w(start_word, 0)); end
        if (frm_cnt !== 16'd1)                  begin n_fail++; $display("FAIL single_frm_cnt: got %0d required 1", frm_cnt); end
        if (tmo_cyc.size() !== 0)               begin n_fail++; $display("FAIL single_no_timeout: got %0d pulses required 0", tmo_cyc.size()); end
        if (fifo_cnt !== 3'd0)                  begin n_fail++; $display("FAIL single_fifo_cnt: got %0d required 0", fifo_cnt); end
        at_neg(d + GAP_CYC - 1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap: got %b required 1", busy); end
        at_neg(d + GAP_CYC);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b required 0", busy); end
        at_neg(d + GAP_CYC + 1);
        n_checks += 6;
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL single_busy_after: got %b required 0", busy); end
        if (start_cyc.size() !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d required 1", start_cyc.size()); end
        if (done_cyc.size() !== 1)  begin n_fail++; $display("FAIL single_done_count: got %0d required 1", done_cyc.size()); end
        if (bus.cmd !== 8'hA5)      begin n_fail++; $display("FAIL single_cmd_held: got %h required a5", bus.cmd); end
        if (bus.data !== 8'h3C)     begin n_fail++; $display("FAIL single_data_held: got %h required 3c", bus.data); end
        if (hold_viol !== 0)        begin n_fail++; $display("FAIL single_hold: %0d changes outside start, required 0", hold_viol); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [5];
        int acc;
        int e;
        w = '{16'h1101, 16'h2202, 16'h3303, 16'h4404, 16'h5505};
        do_reset();
        gen_auto = 1'b1;
        en       = 1'b0;
        for (int i = 0; i < 4; i++) push(w[i][15:8], w[i][7:0], acc);
        bus.req_vld  = 1'b1;
        bus.req_cmd  = w[4][15:8];
        bus.req_data = w[4][7:0];
        repeat (3) @(negedge clk);
        n_checks += 2;
        if (fifo_cnt !== 3'd4)     begin n_fail++; $display("FAIL b2b_full_cnt: got %0d required 4", fifo_cnt); end
        if (bus.req_rdy !== 1'b0)  begin n_fail++; $display("FAIL b2b_stall: req_rdy=%b required 0", bus.req_rdy); end
        @(posedge clk);
        #1;
        en = 1'b1;
        e  = cyc;
        push(w[4][15:8], w[4][7:0], acc);
        n_checks++;
        if (acc !== e + 1) begin n_fail++; $display("FAIL b2b_accept_after_pop: accepted %0d required %0d", acc, e + 1); end
        wait_count(0, 5, 4000, "b2b_done");
        n_checks++;
        if (get_i(start_cyc, 0) !== e + 1) begin n_fail++; $display("FAIL b2b_first_start: at %0d required %0d", get_i(start_cyc, 0), e + 1); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (get_w(start_word, i) !== w[i]) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got %h required %h", i, get_w(start_word, i), w[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (get_i(start_cyc, i + 1) - get_i(done_cyc, i) !== GAP_CYC + 1) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d",
                         i, get_i(start_cyc, i + 1) - get_i(done_cyc, i), GAP_CYC + 1);
            end
        end
        n_checks += 3;
        if (frm_cnt !== 16'd5)  begin n_fail++; $display("FAIL b2b_frm_cnt: got %0d required 5", frm_cnt); end
        if (fifo_cnt !== 3'd0)  begin n_fail++; $display("FAIL b2b_fifo_cnt: got %0d required 0", fifo_cnt); end
        if (hold_viol !== 0)    begin n_fail++; $display("FAIL b2b_hold: %0d changes outside start, required 0", hold_viol); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        int n;
        int m;
        int s0;
        do_reset();
        gen_auto = 1'b0;
        man_csb  = 1'b1;
        en       = 1'b1;
        push(8'h77, 8'h01, n);
        push(8'h78, 8'h02, m);
        s0 = n + 2;
        at_neg(s0 + 10);
        n_checks++;
        if (fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL tmo_fifo_cnt: got %0d required 1", fifo_cnt); end
        wait_count(1, 2, 1500, "tmo_pulses");
        // Counter is 0 in the first WAIT_LOW cycle; expiry at 63, pulse registered one cycle later.
        n_checks += 6;
        if (get_i(start_cyc, 0) !== s0)                           begin n_fail++; $display("FAIL tmo_start0: at %0d required %0d", get_i(start_cyc, 0), s0); end
        if (get_i(tmo_cyc, 0) !== s0 + TIMEOUT_CYC + 1)           begin n_fail++; $display("FAIL tmo_when0: at %0d required %0d", get_i(tmo_cyc, 0), s0 + TIMEOUT_CYC + 1); end
        if (get_i(start_cyc, 1) !== get_i(tmo_cyc, 0) + GAP_CYC + 1) begin n_fail++; $display("FAIL tmo_next_start: at %0d required %0d", get_i(start_cyc, 1), get_i(tmo_cyc, 0) + GAP_CYC + 1); end
        if (get_i(tmo_cyc, 1) !== get_i(start_cyc, 1) + TIMEOUT_CYC + 1) begin n_fail++; $display("FAIL tmo_when1: at %0d required %0d", get_i(tmo_cyc, 1), get_i(start_cyc, 1) + TIMEOUT_CYC + 1); end
        if (done_cyc.size() !== 0)                                begin n_fail++; $display("FAIL tmo_no_done: got %0d pulses required 0", done_cyc.size()); end
        if (frm_cnt !== 16'd0)                                    begin n_fail++; $display("FAIL tmo_frm_cnt: got %0d required 0", frm_cnt); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_race();
        int n;
        int s;
        do_reset();
        gen_auto = 1'b0;
        man_csb  = 1'b1;
        en       = 1'b1;
        push(8'hC3, 8'h5A, n);
        s = n + 2;
        at_cyc(s + 1);
        man_csb = 1'b0;
        at_cyc(s + TIMEOUT_CYC);
        man_csb = 1'b1;
        wait_count(0, 1, 100, "race_done");
        at_neg(s + TIMEOUT_CYC + 20);
        n_checks += 4;
        if (get_i(start_cyc, 0) !== s)                  begin n_fail++; $display("FAIL race_start: at %0d required %0d", get_i(start_cyc, 0), s); end
        if (get_i(done_cyc, 0) !== s + TIMEOUT_CYC + 1) begin n_fail++; $display("FAIL race_done_when: at %0d required %0d", get_i(done_cyc, 0), s + TIMEOUT_CYC + 1); end
        if (tmo_cyc.size() !== 0)                       begin n_fail++; $display("FAIL race_no_timeout: got %0d pulses required 0", tmo_cyc.size()); end
        if (frm_cnt !== 16'd1)                          begin n_fail++; $display("FAIL race_frm_cnt: got %0d required 1", frm_cnt); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_en_pulse();
        int acc;
        int d;
        do_reset();
        gen_auto = 1'b1;
        en       = 1'b0;
        push(8'hE1, 8'h10, acc);
        push(8'hE2, 8'h20, acc);
        at_neg(cyc + 5);
        n_checks += 3;
        if (fifo_cnt !== 3'd2)       begin n_fail++; $display("FAIL en_queued: got %0d required 2", fifo_cnt); end
        if (busy !== 1'b0)           begin n_fail++; $display("FAIL en_parked: busy=%b required 0", busy); end
        if (start_cyc.size() !== 0)  begin n_fail++; $display("FAIL en_no_launch: got %0d starts required 0", start_cyc.size()); end
        @(posedge clk);
        #1;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (bus.start !== 1'b1)  begin n_fail++; $display("FAIL en_start: got %b required 1", bus.start); end
        if (fifo_cnt !== 3'd1)   begin n_fail++; $display("FAIL en_pop: got %0d required 1", fifo_cnt); end
        wait_count(0, 1, 200, "en_done");
        d = get_i(done_cyc, 0);
        at_neg(d + GAP_CYC + 20);
        n_checks += 5;
        if (busy !== 1'b0)                      begin n_fail++; $display("FAIL en_idle: busy=%b required 0", busy); end
        if (start_cyc.size() !== 1)             begin n_fail++; $display("FAIL en_one_frame: got %0d starts required 1", start_cyc.size()); end
        if (fifo_cnt !== 3'd1)                  begin n_fail++; $display("FAIL en_left: got %0d required 1", fifo_cnt); end
        if (frm_cnt !== 16'd1)                  begin n_fail++; $display("FAIL en_frm_cnt: got %0d required 1", frm_cnt); end
        if (get_w(start_word, 0) !== 16'hE110)  begin n_fail++; $display("FAIL en_word: got %h required e110", get_w(start_word, 0)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n;
        int acc;
        int s;
        do_reset();
        gen_auto = 1'b1;
        en       = 1'b1;
        push(8'h91, 8'h01, n);
        push(8'h92, 8'h02, acc);
        push(8'h93, 8'h03, acc);
        push(8'h94, 8'h04, acc);
        s = n + 2;
        at_cyc(s + 10);
        @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b1)      begin n_fail++; $display("FAIL rmid_busy: got %b required 1", busy); end
        if (fifo_cnt !== 3'd3)  begin n_fail++; $display("FAIL rmid_queued: got %0d required 3", fifo_cnt); end
        if (bus.cmd !== 8'h91)  begin n_fail++; $display("FAIL rmid_cmd: got %h required 91", bus.cmd); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks += 7;
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL rmid_async_busy: got %b required 0", busy); end
        if (fifo_cnt !== 3'd0)     begin n_fail++; $display("FAIL rmid_async_fifo: got %0d required 0", fifo_cnt); end
        if (bus.req_rdy !== 1'b1)  begin n_fail++; $display("FAIL rmid_async_rdy: got %b required 1", bus.req_rdy); end
        if (bus.cmd !== 8'h00)     begin n_fail++; $display("FAIL rmid_async_cmd: got %h required 00", bus.cmd); end
        if (bus.data !== 8'h00)    begin n_fail++; $display("FAIL rmid_async_data: got %h required 00", bus.data); end
        if (bus.start !== 1'b0)    begin n_fail++; $display("FAIL rmid_async_start: got %b required 0", bus.start); end
        if (done !== 1'b0)         begin n_fail++; $display("FAIL rmid_async_done: got %b required 0", done); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        at_neg(cyc + 200);
        n_checks += 3;
        if (start_cyc.size() !== 0)  begin n_fail++; $display("FAIL rmid_no_restart: got %0d starts required 0", start_cyc.size()); end
        if (done_cyc.size() !== 0)   begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses required 0", done_cyc.size()); end
        if (fifo_cnt !== 3'd0)       begin n_fail++; $display("FAIL rmid_fifo_after: got %0d required 0", fifo_cnt); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_race();
        test_en_pulse();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
